// File: rtl/xmem_stream_fetcher.sv
// xmem_stream_fetcher: streams num_words SRAM reads from base_addr to the Huffman decoder via a credit-gated skid FIFO.
// Optional FETCH_CHECKSUM_EN adds an XOR checksum of every word handed off.
module xmem_stream_fetcher #(
  parameter int DW         = 32,
  parameter int AW         = 11,
  parameter int LW         = 12,
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [LW-1:0] num_words,
  output logic          busy,
  output logic          done,
  output logic          sram_cen,
  output logic          sram_wen,
  output logic [AW-1:0] sram_addr,
  input  logic [DW-1:0] sram_q,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
`ifdef FETCH_CHECKSUM_EN
  ,
  output logic [DW-1:0] checksum
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] left_q, left_d;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [CW:0]   credit;
  logic          pop, push, issue, accept;
  always_comb begin
    pop        = out_valid & out_ready;
    push       = inflight_q;
    accept     = (state_q == IDLE) & start;
    // Slots already promised (stored + in flight) minus the one leaving this cycle.
    credit     = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    issue      = (state_q == FETCH) && (left_q != '0) && (credit < (CW+1)'(FIFO_DEPTH));
    state_d    = state_q;
    addr_d     = issue ? addr_q + AW'(1) : addr_q;
    left_d     = issue ? left_q - LW'(1) : left_q;
    inflight_d = issue;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    wr_d       = wr_q + PW'(push);
    rd_d       = rd_q + PW'(pop);
    case (state_q)
      IDLE: begin
        addr_d  = accept ? base_addr : addr_q;
        left_d  = accept ? num_words : left_q;
        state_d = !accept ? IDLE : (num_words == '0) ? FINISH : FETCH;
      end
      FETCH:   state_d = (issue && left_q == LW'(1)) ? DRAIN : FETCH;
      DRAIN:   state_d = (!inflight_q && cnt_q == CW'(pop)) ? FINISH : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      left_q     <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      left_q     <= left_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= sram_q;
  end
  assign busy      = (state_q == FETCH) || (state_q == DRAIN);
  assign done      = (state_q == FINISH);
  assign sram_cen  = ~issue;
  assign sram_wen  = 1'b1;
  assign sram_addr = addr_q;
  assign out_valid = (cnt_q != '0);
  assign out_data  = out_valid ? mem_q[rd_q] : '0;
`ifdef FETCH_CHECKSUM_EN
  logic [DW-1:0] csum_q, csum_d;
  always_comb csum_d = accept ? '0 : pop ? csum_q ^ out_data : csum_q;
  always_ff @(posedge clk) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end
  assign checksum = csum_q;
`endif
endmodule

// File: tb/tb_xmem_stream_fetcher.sv
// tb_xmem_stream_fetcher: directed self-checking bench for xmem_stream_fetcher with a 2048x32 SRAM model.
module tb_xmem_stream_fetcher;
  logic        clk = 1'b0;
  logic        reset, start, out_ready;
  logic [10:0] base_addr;
  logic [11:0] num_words;
  logic        busy, done, sram_cen, sram_wen, out_valid;
  logic [10:0] sram_addr;
  logic [31:0] sram_q, out_data;
  logic [31:0] sram [2048];
`ifdef FETCH_CHECKSUM_EN
  logic [31:0] checksum;
`endif
  int checks = 0, errors = 0;
  logic [31:0] words [$];
  logic [10:0] addrs [$];
  int cen_cnt, first_valid, done_cyc, last_pop, done_pulses, credit_err, stall_err, busy_done_err;
  logic [31:0] csum_done, csum_end;

  xmem_stream_fetcher dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_q(sram_q), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef FETCH_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (!sram_cen) sram_q <= sram[sram_addr];

  // rmode 0: out_ready held high; rmode 1: out_ready follows 1,0,0,1. mid_k>0 pulses a second start at that cycle.
  task automatic run(input logic [10:0] b, input logic [11:0] n, input int rmode, input int mid_k);
    int issued = 0, popped = 0;
    logic pv = 1'b0, pr = 1'b0, pop;
    logic [31:0] pd = '0;
    words.delete(); addrs.delete();
    cen_cnt = 0; first_valid = -1; done_cyc = -1; last_pop = -1;
    done_pulses = 0; credit_err = 0; stall_err = 0; busy_done_err = 0;
    csum_done = '0; csum_end = '0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      start     = (k == 0) || (k == mid_k);
      base_addr = (k == 0) ? b : 11'h50;
      num_words = (k == 0) ? n : 12'd2;
      out_ready = (rmode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
      #1;
      if (k > 0) begin
        pop = out_valid & out_ready;
        if (pv && !pr && (!out_valid || out_data !== pd)) stall_err++;
        if (!sram_cen) begin
          if (issued - popped - int'(pop) >= 2) credit_err++;
          issued++; cen_cnt++; addrs.push_back(sram_addr);
        end
        if (out_valid && first_valid < 0) first_valid = k;
        if (pop) begin words.push_back(out_data); popped++; last_pop = k; end
        if (done) begin
          done_pulses++;
          if (busy) busy_done_err++;
          if (done_cyc < 0) begin
            done_cyc = k;
`ifdef FETCH_CHECKSUM_EN
            csum_done = checksum;
`endif
          end
        end
        if (done_cyc >= 0 && k > done_cyc + 3) break;
      end
      pv = out_valid; pr = out_ready; pd = out_data;
    end
`ifdef FETCH_CHECKSUM_EN
    csum_end = checksum;
`endif
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (sram_cen !== 1'b1 || sram_wen !== 1'b1) begin errors++; $display("FAIL reset_cen_wen: got %b%b want 11", sram_cen, sram_wen); end
    checks++; if (sram_addr !== 11'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", sram_addr); end
    checks++; if (out_valid !== 1'b0 || out_data !== 32'd0) begin errors++; $display("FAIL reset_out: got v=%b d=%h want v=0 d=0", out_valid, out_data); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    run(11'd0, 12'd8, 0, -1);
    checks++; if (first_valid !== 3) begin errors++; $display("FAIL basic_latency: got %0d want 3", first_valid); end
    checks++; if (cen_cnt !== 8) begin errors++; $display("FAIL basic_cen_count: got %0d want 8", cen_cnt); end
    checks++; if (words.size() !== 8) begin errors++; $display("FAIL basic_word_count: got %0d want 8", words.size()); end
    for (int i = 0; i < 8 && i < words.size(); i++) begin
      checks++; if (words[i] !== 32'h100 + i) begin errors++; $display("FAIL basic_word%0d: got %h want %h", i, words[i], 32'h100 + i); end
    end
    checks++; if (last_pop !== 10) begin errors++; $display("FAIL basic_throughput: last pop at %0d want 10", last_pop); end
    checks++; if (done_cyc !== 11) begin errors++; $display("FAIL basic_done_cycle: got %0d want 11", done_cyc); end
    checks++; if (done_pulses !== 1 || busy_done_err !== 0) begin errors++; $display("FAIL basic_done_pulse: got %0d pulses busy_err=%0d want 1/0", done_pulses, busy_done_err); end
  endtask

  task automatic test_backpressure();
    run(11'd0, 12'd8, 1, -1);
    checks++; if (words.size() !== 8) begin errors++; $display("FAIL bp_word_count: got %0d want 8", words.size()); end
    for (int i = 0; i < 8 && i < words.size(); i++) begin
      checks++; if (words[i] !== 32'h100 + i) begin errors++; $display("FAIL bp_word%0d: got %h want %h", i, words[i], 32'h100 + i); end
    end
    checks++; if (stall_err !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_err); end
    checks++; if (credit_err !== 0) begin errors++; $display("FAIL bp_credit: got %0d overissues want 0", credit_err); end
    checks++; if (cen_cnt !== 8) begin errors++; $display("FAIL bp_cen_count: got %0d want 8", cen_cnt); end
    checks++; if (done_cyc < 0 || done_cyc !== last_pop + 1) begin errors++; $display("FAIL bp_done_cycle: got %0d want %0d", done_cyc, last_pop + 1); end
  endtask

  task automatic test_wrap();
    logic [10:0] ea [4] = '{11'd2046, 11'd2047, 11'd0, 11'd1};
    logic [31:0] ew [4] = '{32'hAAA0, 32'hAAA1, 32'h100, 32'h101};
    run(11'd2046, 12'd4, 0, -1);
    checks++; if (addrs.size() !== 4 || words.size() !== 4) begin errors++; $display("FAIL wrap_counts: got %0d addrs %0d words want 4/4", addrs.size(), words.size()); end
    for (int i = 0; i < 4 && i < addrs.size() && i < words.size(); i++) begin
      checks++; if (addrs[i] !== ea[i]) begin errors++; $display("FAIL wrap_addr%0d: got %0d want %0d", i, addrs[i], ea[i]); end
      checks++; if (words[i] !== ew[i]) begin errors++; $display("FAIL wrap_word%0d: got %h want %h", i, words[i], ew[i]); end
    end
  endtask

  task automatic test_zero_and_ignored_start();
    run(11'd0, 12'd0, 0, -1);
    checks++; if (cen_cnt !== 0) begin errors++; $display("FAIL zero_cen: got %0d reads want 0", cen_cnt); end
    checks++; if (done_cyc !== 1 || done_pulses !== 1) begin errors++; $display("FAIL zero_done: got cycle %0d pulses %0d want 1/1", done_cyc, done_pulses); end
    checks++; if (words.size() !== 0) begin errors++; $display("FAIL zero_words: got %0d want 0", words.size()); end
    run(11'd0, 12'd8, 0, 5);
    checks++; if (cen_cnt !== 8 || words.size() !== 8) begin errors++; $display("FAIL ign_counts: got %0d reads %0d words want 8/8", cen_cnt, words.size()); end
    for (int i = 0; i < 8 && i < words.size() && i < addrs.size(); i++) begin
      checks++; if (words[i] !== 32'h100 + i || addrs[i] !== 11'(i)) begin errors++; $display("FAIL ign_word%0d: got a=%0d d=%h want a=%0d d=%h", i, addrs[i], words[i], i, 32'h100 + i); end
    end
    checks++; if (done_pulses !== 1) begin errors++; $display("FAIL ign_done_pulses: got %0d want 1", done_pulses); end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    start = 1'b1; base_addr = 11'd0; num_words = 12'd8; out_ready = 1'b0;
    repeat (3) begin @(negedge clk); start = 1'b0; end
    #1;
    checks++; if (out_valid !== 1'b1 || sram_cen !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rst_pre: got v=%b cen=%b busy=%b want 1/1/1", out_valid, sram_cen, busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || sram_cen !== 1'b1) begin errors++; $display("FAIL rst_after: got v=%b busy=%b cen=%b want 0/0/1", out_valid, busy, sram_cen); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_quiet%0d: got v=%b done=%b want 0/0", k, out_valid, done); end
    end
    run(11'h10, 12'd3, 0, -1);
    checks++; if (words.size() !== 3) begin errors++; $display("FAIL rst_new_count: got %0d want 3", words.size()); end
    for (int i = 0; i < 3 && i < words.size(); i++) begin
      checks++; if (words[i] !== 32'h5010 + i) begin errors++; $display("FAIL rst_new_word%0d: got %h want %h", i, words[i], 32'h5010 + i); end
    end
  endtask

`ifdef FETCH_CHECKSUM_EN
  task automatic test_checksum();
    run(11'h20, 12'd4, 1, -1);
    checks++; if (csum_done !== 32'hF) begin errors++; $display("FAIL csum_done: got %h want 0000000f", csum_done); end
    checks++; if (csum_end !== 32'hF) begin errors++; $display("FAIL csum_hold: got %h want 0000000f", csum_end); end
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; out_ready = 1'b0; sram_q = '0;
    for (int i = 0; i < 2048; i++) sram[i] = 32'h5000 + i;
    for (int i = 0; i < 8; i++) sram[i] = 32'h100 + i;
    sram[2046] = 32'hAAA0; sram[2047] = 32'hAAA1;
    sram[32'h20] = 32'h1; sram[32'h21] = 32'h2; sram[32'h22] = 32'h4; sram[32'h23] = 32'h8;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_and_ignored_start();
    test_reset_midop();
`ifdef FETCH_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
